pc_ctrl: RTL and testbench

Fetch-stage program-counter sequencer for the pipelined core. It owns the fetch PC register and decides each cycle whether the PC advances by 4, redirects to a jump or branch target, or holds. Hold cases are a load-use hazard and a slow instruction memory. It also drives the IF/ID stall and flush controls, and halts the core on an instruction-memory timeout.

---
 rtl/pc_ctrl.sv | 87 ++++++++
 tb/tb_pc_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC sequencer with redirect, hazard/imem holds and imem timeout halt
module pc_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        hd_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_o,
    output logic        fetch_valid_o,
    output logic        ifid_stall_o,
    output logic        ifid_flush_o,
    output logic        halt_o,
    output logic [15:0] stall_cnt_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, WAIT = 2'b10, HALT = 2'b11} state_t;
    state_t      state, state_nx;
    logic [31:0] pc_nx, target;
    logic [7:0]  wait_cnt, wait_nx, wait_inc;
    logic        go, redirect, hold, bubble, advance, timeout;
    assign redirect = jump_i | br_taken_i;
    assign target   = jump_i ? jump_target_i : br_target_i;
    assign go       = (state == RUN || state == WAIT) && start_i;
    assign hold     = go && !redirect && hd_i;
    assign bubble   = go && !redirect && !hd_i && !imem_ready_i;
    assign advance  = go && !redirect && !hd_i && imem_ready_i;
    // >= rather than == so a hazard-extended wait past the limit still times out
    assign timeout  = go && !redirect && state == WAIT && !imem_ready_i && wait_cnt >= 8'(WAIT_LIMIT);
    assign wait_inc = wait_cnt + 8'(wait_cnt != 8'hFF);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pc_o        <= RESET_PC;
            wait_cnt    <= '0;
            halt_o      <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state       <= state_nx;
            pc_o        <= pc_nx;
            wait_cnt    <= wait_nx;
            halt_o      <= halt_o | timeout;
            stall_cnt_o <= stall_cnt_o + 16'((hold || bubble) && stall_cnt_o != 16'hFFFF);
        end
    end
    always_comb begin
        state_nx = state;
        pc_nx    = pc_o;
        wait_nx  = wait_cnt;
        if (state == IDLE) begin
            state_nx = start_i ? RUN : IDLE;
            wait_nx  = '0;
        end else if (state != HALT) begin
            if (!start_i) begin
                state_nx = IDLE;
                wait_nx  = '0;
            end else if (redirect) begin
                state_nx = RUN;
                pc_nx    = target & 32'hFFFF_FFFC;
                wait_nx  = '0;
            end else if (timeout) begin
                state_nx = HALT;
            end else if (hd_i) begin
                wait_nx = (state == WAIT) ? wait_inc : wait_cnt;
            end else if (!imem_ready_i) begin
                state_nx = WAIT;
                wait_nx  = (state == RUN) ? 8'd1 : wait_inc;
            end else begin
                state_nx = RUN;
                pc_nx    = pc_o + 32'd4;
                wait_nx  = '0;
            end
        end
    end
    always_comb begin
        fetch_valid_o = !rst_i && advance;
        ifid_stall_o  = !rst_i && hold;
        ifid_flush_o  = !rst_i && (bubble || (go && redirect));
    end
    assign state_o = state;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: table vectors, directed timeout/wrap sequences and random stimulus vs a reference model
module tb_pc_ctrl;
    localparam int LIM = 3;
    logic        clk = 1'b0;
    logic        rst, start, hd, br, jmp, rdy;
    logic [31:0] bt, jt;
    logic [31:0] pc_o;
    logic        fetch_valid_o, ifid_stall_o, ifid_flush_o, halt_o;
    logic [15:0] stall_cnt_o;
    logic [1:0]  state_o;
    int n_cmp = 0;
    int n_err = 0;
    int          m_state = 0;
    logic [31:0] m_pc    = 32'h0;
    int          m_wait  = 0;
    bit          m_halt  = 0;
    int          m_stall = 0;
    always #5 clk = ~clk;
    pc_ctrl #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .hd_i(hd),
        .br_taken_i(br), .br_target_i(bt), .jump_i(jmp), .jump_target_i(jt),
        .imem_ready_i(rdy), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
        .ifid_stall_o(ifid_stall_o), .ifid_flush_o(ifid_flush_o), .halt_o(halt_o),
        .stall_cnt_o(stall_cnt_o), .state_o(state_o)
    );
    typedef struct {
        bit s, h, b; logic [31:0] bt; bit j; logic [31:0] jt; bit r;
        logic [31:0] pc; int st; bit fv, stl, fl; int sc;
    } vec_t;
    vec_t tbl [16];
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    // model of the sequencer written directly from the fetch rules
    task automatic model_outputs(output bit fv, output bit st, output bit fl);
        bit live;
        live = !rst && (m_state == 1 || m_state == 2) && start;
        fv = live && !(jmp || br) && !hd && rdy;
        st = live && !(jmp || br) && hd;
        fl = live && ((jmp || br) || (!hd && !rdy));
    endtask
    task automatic model_advance();
        bit to;
        if (rst) begin
            m_state = 0; m_pc = 32'h0; m_wait = 0; m_halt = 0; m_stall = 0;
            return;
        end
        if (m_state == 0) begin
            if (start) m_state = 1;
            m_wait = 0;
        end else if (m_state != 3) begin
            if (!start) begin
                m_state = 0; m_wait = 0;
            end else if (jmp || br) begin
                m_pc = (jmp ? jt : bt) & 32'hFFFF_FFFC; m_state = 1; m_wait = 0;
            end else begin
                if ((hd || !rdy) && m_stall < 65535) m_stall++;
                to = (m_state == 2) && !rdy && m_wait >= LIM;
                if (hd) begin
                    if (m_state == 2 && m_wait < 255) m_wait++;
                end else if (!rdy) begin
                    m_wait = (m_state == 1) ? 1 : (m_wait < 255 ? m_wait + 1 : 255);
                    m_state = 2;
                end else begin
                    m_pc = m_pc + 32'd4; m_state = 1; m_wait = 0;
                end
                if (to) begin
                    m_state = 3; m_halt = 1;
                end
            end
        end
    endtask
    task automatic cycle();
        bit fv, st, fl;
        #2;
        model_outputs(fv, st, fl);
        chk("pc", pc_o, m_pc);
        chk("state", 32'(state_o), 32'(m_state));
        chk("halt", 32'(halt_o), 32'(m_halt));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
        chk("fetch_valid", 32'(fetch_valid_o), 32'(fv));
        chk("ifid_stall", 32'(ifid_stall_o), 32'(st));
        chk("ifid_flush", 32'(ifid_flush_o), 32'(fl));
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask
    task automatic go(bit s, bit h, bit b, logic [31:0] b_t, bit j, logic [31:0] j_t, bit r);
        start = s; hd = h; br = b; bt = b_t; jmp = j; jt = j_t; rdy = r;
        cycle();
    endtask
    task automatic do_reset();
        rst = 1'b1;
        go(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1; start = 0; hd = 0; br = 0; jmp = 0; rdy = 0; bt = 0; jt = 0;
        tbl[0]  = '{1,0,0,0,0,0,1, 32'h0,   0,0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0,1, 32'h0,   1,1,0,0,0};
        tbl[2]  = '{1,0,0,0,0,0,1, 32'h4,   1,1,0,0,0};
        tbl[3]  = '{1,0,0,0,0,0,1, 32'h8,   1,1,0,0,0};
        tbl[4]  = '{1,0,0,0,0,0,1, 32'hC,   1,1,0,0,0};
        tbl[5]  = '{1,1,0,0,0,0,1, 32'h10,  1,0,1,0,0};
        tbl[6]  = '{1,1,0,0,0,0,1, 32'h10,  1,0,1,0,1};
        tbl[7]  = '{1,0,0,0,0,0,1, 32'h10,  1,1,0,0,2};
        tbl[8]  = '{1,1,1,32'h43,0,0,1, 32'h14, 1,0,0,1,2};
        tbl[9]  = '{1,0,1,32'h200,1,32'h100,1, 32'h40, 1,0,0,1,2};
        tbl[10] = '{1,0,0,0,0,0,1, 32'h100, 1,1,0,0,2};
        tbl[11] = '{0,0,0,0,0,0,1, 32'h104, 1,0,0,0,2};
        tbl[12] = '{0,0,0,0,0,0,1, 32'h104, 0,0,0,0,2};
        tbl[13] = '{1,0,0,0,0,0,1, 32'h104, 0,0,0,0,2};
        tbl[14] = '{1,0,0,0,0,0,1, 32'h104, 1,1,0,0,2};
        tbl[15] = '{1,0,0,0,0,0,1, 32'h108, 1,1,0,0,2};
        @(negedge clk);
        cycle();
        rst = 1'b0;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_halt", 32'(halt_o), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].s; hd = tbl[i].h; br = tbl[i].b; bt = tbl[i].bt;
            jmp = tbl[i].j; jt = tbl[i].jt; rdy = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
            chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_fv", i), 32'(fetch_valid_o), 32'(tbl[i].fv));
            chk($sformatf("tbl%0d_stall", i), 32'(ifid_stall_o), 32'(tbl[i].stl));
            chk($sformatf("tbl%0d_flush", i), 32'(ifid_flush_o), 32'(tbl[i].fl));
            chk($sformatf("tbl%0d_stall_cnt", i), 32'(stall_cnt_o), 32'(tbl[i].sc));
            cycle();
        end
        // reset gates the combinational controls even while running
        rst = 1'b1; start = 1; hd = 0; br = 0; jmp = 0; rdy = 1;
        #1 chk("rst_gates_fv", 32'(fetch_valid_o), 32'd0);
        cycle();
        rst = 1'b0;
        // imem timeout into HALT, then reset out of HALT
        go(1,0,0,0,0,0,1);
        go(1,0,0,0,0,0,1);
        chk("pre_wait_pc", pc_o, 32'h4);
        for (int i = 0; i < 3; i++) begin
            go(1,0,0,0,0,0,0);
            chk($sformatf("wait%0d_state", i), 32'(state_o), 32'd2);
        end
        go(1,0,0,0,0,0,0);
        chk("timeout_state", 32'(state_o), 32'd3);
        chk("timeout_halt", 32'(halt_o), 32'd1);
        for (int i = 0; i < 3; i++) go(1,0,1,32'h8,1,32'h20,1);
        chk("halt_pc_frozen", pc_o, 32'h4);
        chk("halt_state", 32'(state_o), 32'd3);
        do_reset();
        chk("halt_rst_pc", pc_o, 32'h0);
        chk("halt_rst_state", 32'(state_o), 32'd0);
        chk("halt_rst_halt", 32'(halt_o), 32'd0);
        // redirect on the timeout cycle wins, then PC wrap-around
        go(1,0,0,0,0,0,1);
        go(1,0,0,0,0,0,1);
        for (int i = 0; i < 3; i++) go(1,0,0,0,0,0,0);
        go(1,0,0,0,1,32'hFFFF_FFFF,0);
        chk("timeout_redirect_state", 32'(state_o), 32'd1);
        chk("timeout_redirect_halt", 32'(halt_o), 32'd0);
        chk("timeout_redirect_pc", pc_o, 32'hFFFF_FFFC);
        go(1,0,0,0,0,0,1);
        chk("wrap_pc", pc_o, 32'h0);
        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(99) == 0);
            start = ($urandom_range(19) != 0);
            hd    = ($urandom_range(4) == 0);
            br    = ($urandom_range(9) == 0);
            jmp   = ($urandom_range(14) == 0);
            bt    = $urandom;
            jt    = $urandom;
            rdy   = ($urandom_range(9) < 7);
            cycle();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
